// File: rtl/cursor_input_ctrl.sv
// -----------------------------------------------------------------------------
// cursor_input_ctrl
//
// Front end of the chess game core. Conditions the four board pushbuttons
// (2-FF synchronizer, per-key debounce, press detection), runs an auto-repeat
// state machine and keeps a wrapping cursor on the 8x8 board.
//
// Ports:
//   CLOCK_50    in   1  system clock, all state on the rising edge
//   reset_n     in   1  asynchronous active-low reset
//   KEY         in   4  raw pushbuttons, active-low: [3]=up [2]=down
//                       [1]=left [0]=right
//   cursor_col  out  3  cursor file 0..7
//   cursor_row  out  3  cursor rank 0..7
//   move_valid  out  1  one-cycle strobe, same cycle the cursor changes
//   move_dir    out  2  last move: 0=up 1=down 2=left 3=right
//   HEX1        out  7  active-low gfedcba, cursor_col+1
//   HEX0        out  7  active-low gfedcba, cursor_row+1
//
// Build option:
//   CURSOR_AUTOREPEAT_EN  defined   -> held key auto-repeats (REPEAT state and
//                                      repeat timer compiled in)
//                         undefined -> exactly one move per press
// -----------------------------------------------------------------------------
module cursor_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 7500000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [3:0] KEY,
    output logic [2:0] cursor_col,
    output logic [2:0] cursor_row,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

`ifdef CURSOR_AUTOREPEAT_EN
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BLOCK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD, BLOCK} state_t;
`endif

    // -------------------------------------------------------------------------
    // Synchronizer: reset to the released level so no spurious press appears
    // -------------------------------------------------------------------------
    logic [3:0] sync1;
    logic [3:0] sync2;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: a key must hold a new level for DEBOUNCE_CYCLES cycles.
    // press is registered on the same edge the debounced level falls, so the
    // FSM sees press and the new debounced level together one cycle later.
    // -------------------------------------------------------------------------
    logic [DW-1:0] db_cnt [4];
    logic [3:0]    db_state;
    logic [3:0]    press;

    // NOTE: the counter array is only four entries and its start value matters
    // (a key held through reset must re-debounce from zero), so it is reset
    // like ordinary flops rather than left to power-up contents.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            db_state <= 4'hF;
            press    <= 4'h0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            press <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_state[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                    press[i]    <= ~sync2[i];   // only the 1->0 flip is a press
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Key bookkeeping and candidate next cursor position
    // -------------------------------------------------------------------------
    state_t     state;
    logic [1:0] held_key;
    logic [3:0] pressed;
    logic [3:0] other_pressed;
    logic [1:0] press_idx;
    logic [1:0] sel_key;
    logic [2:0] next_col;
    logic [2:0] next_row;
    logic       single_press;
    logic       multi_pressed;

    assign pressed       = ~db_state;
    assign other_pressed = pressed & ~(4'b0001 << held_key);
    assign single_press  = ($countones(press) == 1) && ($countones(pressed) == 1);
    assign multi_pressed = ($countones(pressed) >= 2);

    // NOTE: every always_comb output gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        press_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (press[i]) press_idx = 2'(i);
        end
    end

    // In IDLE the move comes from the fresh press; later from the latched key.
    assign sel_key = (state == IDLE) ? press_idx : held_key;

    always_comb begin
        next_col = cursor_col;
        next_row = cursor_row;
        unique case (sel_key)
            2'd3: next_row = cursor_row + 3'd1;   // up, 7 wraps to 0
            2'd2: next_row = cursor_row - 3'd1;   // down, 0 wraps to 7
            2'd1: next_col = cursor_col - 3'd1;   // left
            2'd0: next_col = cursor_col + 3'd1;   // right
        endcase
    end

    // -------------------------------------------------------------------------
    // Auto-repeat FSM with registered cursor and strobe.
    // Key index i maps to direction 3-i, i.e. the bitwise inverse.
    // -------------------------------------------------------------------------
`ifdef CURSOR_AUTOREPEAT_EN
    logic [TW-1:0] timer;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            held_key   <= 2'd0;
            cursor_col <= 3'd0;
            cursor_row <= 3'd0;
            move_valid <= 1'b0;
            move_dir   <= 2'd0;
`ifdef CURSOR_AUTOREPEAT_EN
            timer      <= '0;
`endif
        end else begin
            move_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (multi_pressed) begin
                        state <= BLOCK;
                    end else if (single_press) begin
                        cursor_col <= next_col;
                        cursor_row <= next_row;
                        move_dir   <= ~sel_key;
                        move_valid <= 1'b1;
                        held_key   <= press_idx;
`ifdef CURSOR_AUTOREPEAT_EN
                        timer      <= DELAY_LOAD;
`endif
                        state      <= HOLD;
                    end
                end
                // A second key wins over a simultaneous release so the FSM
                // never returns to IDLE with a key still held down.
                HOLD: begin
                    if (|other_pressed) begin
                        state <= BLOCK;
                    end else if (db_state[held_key]) begin
                        state <= IDLE;
                    end
`ifdef CURSOR_AUTOREPEAT_EN
                    else if (timer == '0) begin
                        cursor_col <= next_col;
                        cursor_row <= next_row;
                        move_dir   <= ~sel_key;
                        move_valid <= 1'b1;
                        timer      <= PERIOD_LOAD;
                        state      <= REPEAT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
`endif
                end
`ifdef CURSOR_AUTOREPEAT_EN
                REPEAT: begin
                    if (|other_pressed) begin
                        state <= BLOCK;
                    end else if (db_state[held_key]) begin
                        state <= IDLE;
                    end else if (timer == '0) begin
                        cursor_col <= next_col;
                        cursor_row <= next_row;
                        move_dir   <= ~sel_key;
                        move_valid <= 1'b1;
                        timer      <= PERIOD_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`endif
                BLOCK: begin
                    if (&db_state) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Seven-segment digits: value v shows as decimal v+1, active-low gfedcba
    // -------------------------------------------------------------------------
    function automatic logic [6:0] seg_digit(input logic [2:0] v);
        logic [6:0] seg;
        unique case (v)
            3'd0: seg = 7'b1111001;
            3'd1: seg = 7'b0100100;
            3'd2: seg = 7'b0110000;
            3'd3: seg = 7'b0011001;
            3'd4: seg = 7'b0010010;
            3'd5: seg = 7'b0000010;
            3'd6: seg = 7'b1111000;
            3'd7: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    assign HEX1 = seg_digit(cursor_col);
    assign HEX0 = seg_digit(cursor_row);

endmodule

// File: tb/tb_cursor_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cursor_input_ctrl
//
// Self-checking bench for cursor_input_ctrl with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=6. A press driven just after a clock edge
// produces move_valid after the 7th following edge (2 sync + 4 debounce + 1).
// Auto-repeat expectations follow CURSOR_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module tb_cursor_input_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic [2:0] cursor_col;
    logic [2:0] cursor_row;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [6:0] hex1;
    logic [6:0] hex0;

    int n_cmp  = 0;
    int n_bad  = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    cursor_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (6)
    ) dut (
        .CLOCK_50  (clk),
        .reset_n   (rst_n),
        .KEY       (key),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .HEX1      (hex1),
        .HEX0      (hex0)
    );

    // Count every move strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (move_valid) pulses <= pulses + 1;
    end

    typedef struct {
        logic [1:0] k;       // key index pressed
        logic [2:0] col;
        logic [2:0] row;
        logic [1:0] dir;
        logic [6:0] h1;
        logic [6:0] h0;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_pos(input string tag, input logic [2:0] c, input logic [2:0] r);
        check({tag, "_col"}, 32'(cursor_col), 32'(c));
        check({tag, "_row"}, 32'(cursor_row), 32'(r));
    endtask

    int base;

    initial begin
        // Expected results, computed by hand; cursor starts at col 1, row 0
        // (after the bounce sequence).
        vecs[0] = '{k: 2'd2, col: 3'd1, row: 3'd7, dir: 2'd1, h1: 7'b0100100, h0: 7'b0000000};
        vecs[1] = '{k: 2'd3, col: 3'd1, row: 3'd0, dir: 2'd0, h1: 7'b0100100, h0: 7'b1111001};
        vecs[2] = '{k: 2'd1, col: 3'd0, row: 3'd0, dir: 2'd2, h1: 7'b1111001, h0: 7'b1111001};
        vecs[3] = '{k: 2'd1, col: 3'd7, row: 3'd0, dir: 2'd2, h1: 7'b0000000, h0: 7'b1111001};
        vecs[4] = '{k: 2'd0, col: 3'd0, row: 3'd0, dir: 2'd3, h1: 7'b1111001, h0: 7'b1111001};
        vecs[5] = '{k: 2'd0, col: 3'd1, row: 3'd0, dir: 2'd3, h1: 7'b0100100, h0: 7'b1111001};
        vecs[6] = '{k: 2'd3, col: 3'd1, row: 3'd1, dir: 2'd0, h1: 7'b0100100, h0: 7'b0100100};
        vecs[7] = '{k: 2'd3, col: 3'd1, row: 3'd2, dir: 2'd0, h1: 7'b0100100, h0: 7'b0110000};
        vecs[8] = '{k: 2'd2, col: 3'd1, row: 3'd1, dir: 2'd1, h1: 7'b0100100, h0: 7'b0100100};

        // ---------------- Reset ----------------
        rst_n = 1'b0;
        key   = 4'hF;
        #2;
        check_pos("rst", 3'd0, 3'd0);
        check("rst_mv",   32'(move_valid), 32'd0);
        check("rst_dir",  32'(move_dir),   32'd0);
        check("rst_hex1", 32'(hex1), 32'(7'b1111001));
        check("rst_hex0", 32'(hex0), 32'(7'b1111001));
        step(3);
        rst_n = 1'b1;
        step(5);
        check_pos("post_rst", 3'd0, 3'd0);
        check("post_rst_mv",   32'(move_valid), 32'd0);
        check("post_rst_hex1", 32'(hex1), 32'(7'b1111001));

        // ---------------- Bounce on KEY[0] ----------------
        base = pulses;
        for (int p = 0; p < 6; p++) begin
            key = (p % 2 == 0) ? 4'hE : 4'hF;
            step(2);
        end
        key = 4'hE;
        step(6);
        check("bounce_early_mv", 32'(move_valid), 32'd0);
        check("bounce_early_cnt", 32'(pulses - base), 32'd0);
        step(1);
        check("bounce_mv", 32'(move_valid), 32'd1);
        check_pos("bounce", 3'd1, 3'd0);
        check("bounce_dir",  32'(move_dir), 32'd3);
        check("bounce_hex1", 32'(hex1), 32'(7'b0100100));
        step(1);
        key = 4'hF;
        step(10);
        check("bounce_pulses", 32'(pulses - base), 32'd1);

        // ---------------- Table: single presses incl. wrap ----------------
        for (int i = 0; i < 9; i++) begin
            base = pulses;
            key  = 4'hF & ~(4'b0001 << vecs[i].k);
            step(6);
            check($sformatf("v%0d_early_mv", i), 32'(move_valid), 32'd0);
            step(1);
            check($sformatf("v%0d_mv", i), 32'(move_valid), 32'd1);
            check_pos($sformatf("v%0d", i), vecs[i].col, vecs[i].row);
            check($sformatf("v%0d_dir", i),  32'(move_dir), 32'(vecs[i].dir));
            check($sformatf("v%0d_hex1", i), 32'(hex1), 32'(vecs[i].h1));
            check($sformatf("v%0d_hex0", i), 32'(hex0), 32'(vecs[i].h0));
            step(1);
            check($sformatf("v%0d_mv_off", i), 32'(move_valid), 32'd0);
            key = 4'hF;
            step(10);
            check($sformatf("v%0d_pulses", i), 32'(pulses - base), 32'd1);
        end

        // ---------------- Auto-repeat on KEY[3], from (1,1) ----------------
        base = pulses;
        key  = 4'h7;
        step(7);
        check("ar_first_mv", 32'(move_valid), 32'd1);
        check_pos("ar_first", 3'd1, 3'd2);
`ifdef CURSOR_AUTOREPEAT_EN
        step(19);
        check("ar_delay_quiet", 32'(move_valid), 32'd0);
        step(1);
        check("ar_rep0_mv", 32'(move_valid), 32'd1);
        check_pos("ar_rep0", 3'd1, 3'd3);
        for (int r = 1; r <= 5; r++) begin
            step(5);
            check($sformatf("ar_rep%0d_quiet", r), 32'(move_valid), 32'd0);
            step(1);
            check($sformatf("ar_rep%0d_mv", r), 32'(move_valid), 32'd1);
            check($sformatf("ar_rep%0d_row", r), 32'(cursor_row), 32'((3 + r) % 8));
        end
        check("ar_pulses", 32'(pulses - base), 32'd7);
        key = 4'hF;
        step(10);
        check_pos("ar_end", 3'd1, 3'd0);
`else
        step(60);
        check("ar_pulses", 32'(pulses - base), 32'd1);
        check_pos("ar_end", 3'd1, 3'd2);
        key = 4'hF;
        step(10);
`endif

        // ---------------- Conflict: KEY[1] and KEY[0] together ----------------
        base = pulses;
        key  = 4'hC;
        step(12);
        check("conf_both_pulses", 32'(pulses - base), 32'd0);
        key = 4'hD;           // release KEY[0], keep KEY[1]
        step(30);
        check("conf_one_pulses", 32'(pulses - base), 32'd0);
        check("conf_col", 32'(cursor_col), 32'd1);
        key = 4'hF;
        step(10);
        key = 4'hD;           // fresh KEY[1] press
        step(7);
        check("conf_left_mv",  32'(move_valid), 32'd1);
        check("conf_left_col", 32'(cursor_col), 32'd0);
        check("conf_left_dir", 32'(move_dir), 32'd2);
        key = 4'hF;
        step(10);

        // ---------------- Reset mid-hold / mid-repeat ----------------
        key = 4'h7;
        step(7);
        check("mr_first_mv", 32'(move_valid), 32'd1);
`ifdef CURSOR_AUTOREPEAT_EN
        step(20);
        check("mr_rep_mv", 32'(move_valid), 32'd1);
`else
        step(20);
`endif
        rst_n = 1'b0;
        #1;
        check_pos("mr_rst", 3'd0, 3'd0);
        check("mr_rst_mv",  32'(move_valid), 32'd0);
        check("mr_rst_hex0", 32'(hex0), 32'(7'b1111001));
        step(3);
        rst_n = 1'b1;
        base = pulses;
        step(6);
        check("mr_early_mv", 32'(move_valid), 32'd0);
        step(1);
        check("mr_mv", 32'(move_valid), 32'd1);
        check_pos("mr", 3'd0, 3'd1);
        check("mr_hex0", 32'(hex0), 32'(7'b0100100));
`ifdef CURSOR_AUTOREPEAT_EN
        step(19);
        check("mr_delay_quiet", 32'(move_valid), 32'd0);
        step(1);
        check("mr_rep_restart_mv", 32'(move_valid), 32'd1);
        check_pos("mr_rep_restart", 3'd0, 3'd2);
`else
        step(20);
        check("mr_single_pulses", 32'(pulses - base), 32'd1);
`endif
        key = 4'hF;
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
